lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data width; the block is defined for 32 only.
REQ-002 Parameter ADDR_SIZE, default 32, address width.
REQ-003 Parameter ITAG_WIDTH, default 2, instruction tag width.
REQ-004 Parameter OUTS_DEPTH, default 2, maximum outstanding bus requests; power of 2, at least 1.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 agu_cmd_valid  in  1  / agu_cmd_ready  out  1  AGU command handshake.
REQ-008 agu_cmd_addr  in  ADDR_SIZE  / agu_cmd_read  in  1 (1=load) / agu_cmd_wdata  in  XLEN (lane-replicated store data).
REQ-009 agu_cmd_itag  in  ITAG_WIDTH  / agu_cmd_size  in  2 (00 byte, 01 half, 10 word) / agu_cmd_usign  in  1 (zero-extend load).
REQ-010 mem_cmd_valid  out  1  / mem_cmd_ready  in  1  data-bus request handshake.
REQ-011 mem_cmd_addr  out  ADDR_SIZE  / mem_cmd_read  out  1  / mem_cmd_wdata  out  XLEN  / mem_cmd_wmask  out  XLEN/8.
REQ-012 mem_rsp_valid  in  1  / mem_rsp_ready  out  1  / mem_rsp_rdata  in  XLEN  / mem_rsp_err  in  1  bus response.
REQ-013 lsu_o_valid  out  1  / lsu_o_ready  in  1  completion handshake to commit/writeback.
REQ-014 lsu_o_wdat  out  XLEN  / lsu_o_itag  out  ITAG_WIDTH  / lsu_o_err  out  1 (bus error) / lsu_o_misalgn  out  1.

Function
REQ-015 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11; all other commands are aligned.
REQ-016 Aligned command: mem_cmd_valid = agu_cmd_valid & ~fifo_full & ~err_pend; mem_cmd_* fields pass through combinationally; agu_cmd_ready = mem_cmd_ready & ~fifo_full & ~err_pend.
REQ-017 wmask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; load drives 4'b0000.
REQ-018 Aligned handshake pushes {itag, read, size, usign, addr[1:0]} into an in-order outstanding FIFO of OUTS_DEPTH entries.
REQ-019 Push into a full FIFO is blocked even if a pop occurs in the same cycle; simultaneous push and pop on a non-full FIFO keeps count unchanged.
REQ-020 Pointers wrap modulo OUTS_DEPTH; count ranges 0..OUTS_DEPTH.
REQ-021 Misaligned command: no bus request; accepted only when FIFO empty and err_pend=0, agu_cmd_ready=1 in that case; accept sets err_pend and latches the itag.
REQ-022 err_pend state: lsu_o_valid=1, lsu_o_misalgn=1, lsu_o_err=0, lsu_o_wdat=0, lsu_o_itag=latched tag; cleared on lsu_o handshake.
REQ-023 Otherwise lsu_o_valid = mem_rsp_valid & ~fifo_empty; mem_rsp_ready = lsu_o_ready & ~fifo_empty; zero-cycle pass-through, no response buffering.
REQ-024 A response handshake pops the FIFO head; lsu_o_itag = head itag, lsu_o_err = mem_rsp_err, lsu_o_misalgn=0.
REQ-025 Load data: shift mem_rsp_rdata right by 8*head addr[1:0], then take byte/half/word and sign-extend (usign=0) or zero-extend (usign=1).
REQ-026 Store completion and any error completion drive lsu_o_wdat=0.
REQ-027 Completions are strictly in command-acceptance order; err_pend never coexists with a non-empty FIFO.
REQ-028 mem_rsp_valid while the FIFO is empty is a protocol violation; mem_rsp_ready stays 0 and no state changes.

Reset
REQ-029 While rst=1 at a clock edge: FIFO count, pointers and err_pend cleared; in-flight bus requests are abandoned.
REQ-030 Outputs after reset: agu_cmd_ready follows mem_cmd_ready, mem_cmd_valid=0 unless agu_cmd_valid, mem_rsp_ready=0, lsu_o_valid=0.

Verification
REQ-031 Load byte addr 0x1003 usign=0, rsp rdata 0x80FF_FF12 -> wmask 0000, lsu_o_wdat 0xFFFF_FF80, itag echoed.
REQ-032 Store half addr 0x2002 wdata 0xBEEF_BEEF -> mem_cmd_wmask 1100, wdata passed unchanged, completion wdat 0, err 0.
REQ-033 Two loads accepted with no response, third presented -> agu_cmd_ready=0 until first response handshakes; completions in itag order.
REQ-034 Word load addr 0x3002 with FIFO empty -> no mem_cmd_valid, next cycle lsu_o_valid=1 misalgn=1; held until lsu_o_ready.
REQ-035 Response with mem_rsp_err=1 and lsu_o_ready=0 for 3 cycles -> mem_rsp_ready=0 throughout, then lsu_o_err=1 on handshake.
REQ-036 rst asserted with 2 outstanding -> next cycle count 0, lsu_o_valid=0, new command accepted normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: forwards aligned AGU commands to the data bus and tracks them in an in-order outstanding FIFO.
// Load data is aligned and extended on completion; misaligned commands complete locally with a misalignment flag.
module lsu_ctrl #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int ITAG_WIDTH = 2,
  parameter int OUTS_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  agu_cmd_valid,
  output logic                  agu_cmd_ready,
  input  logic [ADDR_SIZE-1:0]  agu_cmd_addr,
  input  logic                  agu_cmd_read,
  input  logic [XLEN-1:0]       agu_cmd_wdata,
  input  logic [ITAG_WIDTH-1:0] agu_cmd_itag,
  input  logic [1:0]            agu_cmd_size,
  input  logic                  agu_cmd_usign,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [ADDR_SIZE-1:0]  mem_cmd_addr,
  output logic                  mem_cmd_read,
  output logic [XLEN-1:0]       mem_cmd_wdata,
  output logic [XLEN/8-1:0]     mem_cmd_wmask,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [XLEN-1:0]       mem_rsp_rdata,
  input  logic                  mem_rsp_err,
  output logic                  lsu_o_valid,
  input  logic                  lsu_o_ready,
  output logic [XLEN-1:0]       lsu_o_wdat,
  output logic [ITAG_WIDTH-1:0] lsu_o_itag,
  output logic                  lsu_o_err,
  output logic                  lsu_o_misalgn
);

  localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTS_DEPTH + 1);
  localparam int ENT_W = ITAG_WIDTH + 6;

  logic [ENT_W-1:0]      r_fifo [OUTS_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err_pend;
  logic [ITAG_WIDTH-1:0] r_err_itag;

  logic                  w_misalgn;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_mis_acc;
  logic [ENT_W-1:0]      w_head;
  logic [ITAG_WIDTH-1:0] w_h_itag;
  logic                  w_h_read;
  logic [1:0]            w_h_size;
  logic                  w_h_usign;
  logic [1:0]            w_h_off;
  logic [XLEN-1:0]       w_shift;
  logic [XLEN-1:0]       w_ldata;

  assign w_full  = (r_count == CNT_W'(OUTS_DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_misalgn = (agu_cmd_size == 2'b11)
                   | ((agu_cmd_size == 2'b01) & agu_cmd_addr[0])
                   | ((agu_cmd_size == 2'b10) & (agu_cmd_addr[1:0] != 2'b00));

  assign mem_cmd_valid = agu_cmd_valid & ~w_misalgn & ~w_full & ~r_err_pend;
  assign mem_cmd_addr  = agu_cmd_addr;
  assign mem_cmd_read  = agu_cmd_read;
  assign mem_cmd_wdata = agu_cmd_wdata;
  assign agu_cmd_ready = w_misalgn ? (w_empty & ~r_err_pend)
                                   : (mem_cmd_ready & ~w_full & ~r_err_pend);

  assign w_push    = mem_cmd_valid & mem_cmd_ready;
  assign w_mis_acc = agu_cmd_valid & w_misalgn & w_empty & ~r_err_pend;

  assign w_head = r_fifo[r_rptr];
  assign {w_h_itag, w_h_read, w_h_size, w_h_usign, w_h_off} = w_head;

  // Responses reach writeback only when a request is outstanding; a stray response is never acknowledged.
  assign mem_rsp_ready = lsu_o_ready & ~w_empty & ~r_err_pend;
  assign w_pop         = mem_rsp_valid & mem_rsp_ready;
  assign w_shift       = mem_rsp_rdata >> {w_h_off, 3'b000};

  // Write byte-mask generation from size and address offset
  always_comb begin
    mem_cmd_wmask = {(XLEN/8){1'b0}};
    if (agu_cmd_read) begin
      mem_cmd_wmask = {(XLEN/8){1'b0}};
    end else begin
      case (agu_cmd_size)
        2'b00:   mem_cmd_wmask = 4'b0001 << agu_cmd_addr[1:0];
        2'b01:   mem_cmd_wmask = 4'b0011 << agu_cmd_addr[1:0];
        default: mem_cmd_wmask = 4'b1111;
      endcase
    end
  end

  // Load data lane selection and sign/zero extension
  always_comb begin
    w_ldata = w_shift;
    case (w_h_size)
      2'b00:   w_ldata = {{(XLEN-8){~w_h_usign & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ldata = {{(XLEN-16){~w_h_usign & w_shift[15]}}, w_shift[15:0]};
      default: w_ldata = w_shift;
    endcase
  end

  // Completion channel: misalignment report has priority over bus responses
  always_comb begin
    lsu_o_valid   = 1'b0;
    lsu_o_wdat    = {XLEN{1'b0}};
    lsu_o_itag    = w_h_itag;
    lsu_o_err     = 1'b0;
    lsu_o_misalgn = 1'b0;
    if (r_err_pend) begin
      lsu_o_valid   = 1'b1;
      lsu_o_itag    = r_err_itag;
      lsu_o_misalgn = 1'b1;
    end else begin
      lsu_o_valid = mem_rsp_valid & ~w_empty;
      lsu_o_err   = mem_rsp_err;
      if (w_h_read && !mem_rsp_err) begin
        lsu_o_wdat = w_ldata;
      end else begin
        lsu_o_wdat = {XLEN{1'b0}};
      end
    end
  end

  // Outstanding FIFO pointers, occupancy and misalignment-pending state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= {PTR_W{1'b0}};
      r_rptr     <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_err_pend <= 1'b0;
      r_err_itag <= {ITAG_WIDTH{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_W'(OUTS_DEPTH - 1)) ? {PTR_W{1'b0}} : r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(OUTS_DEPTH - 1)) ? {PTR_W{1'b0}} : r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_mis_acc) begin
        r_err_pend <= 1'b1;
        r_err_itag <= agu_cmd_itag;
      end else if (r_err_pend && lsu_o_ready) begin
        r_err_pend <= 1'b0;
      end
    end
  end

  // FIFO entry storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {agu_cmd_itag, agu_cmd_read, agu_cmd_size, agu_cmd_usign, agu_cmd_addr[1:0]};
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned loads/stores, FIFO back-pressure, misalignment, bus error and reset.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [31:0] agu_cmd_addr, agu_cmd_wdata;
  logic [1:0]  agu_cmd_itag, agu_cmd_size;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_read;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [3:0]  mem_cmd_wmask;
  logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        lsu_o_valid, lsu_o_ready, lsu_o_err, lsu_o_misalgn;
  logic [31:0] lsu_o_wdat;
  logic [1:0]  lsu_o_itag;

  int vectors = 0;
  int miscompares = 0;

  lsu_ctrl #(.XLEN(32), .ADDR_SIZE(32), .ITAG_WIDTH(2), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_itag(agu_cmd_itag),
    .agu_cmd_size(agu_cmd_size), .agu_cmd_usign(agu_cmd_usign),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_read(mem_cmd_read),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wmask(mem_cmd_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_o_wdat(lsu_o_wdat), .lsu_o_itag(lsu_o_itag),
    .lsu_o_err(lsu_o_err), .lsu_o_misalgn(lsu_o_misalgn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic agu(input logic v, input logic [31:0] a, input logic rd, input logic [1:0] sz,
                     input logic us, input logic [1:0] tag, input logic [31:0] wd);
    agu_cmd_valid = v; agu_cmd_addr = a; agu_cmd_read = rd; agu_cmd_size = sz;
    agu_cmd_usign = us; agu_cmd_itag = tag; agu_cmd_wdata = wd;
  endtask

  task automatic rsp(input logic v, input logic [31:0] d, input logic e);
    mem_rsp_valid = v; mem_rsp_rdata = d; mem_rsp_err = e;
  endtask

  initial begin
    rst = 1'b1;
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    rsp(1'b0, 32'h0, 1'b0);
    mem_cmd_ready = 1'b1;
    lsu_o_ready   = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_agu_ready", 32'(agu_cmd_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("rst_lsu_valid", 32'(lsu_o_valid), 32'd0);

    // signed byte load from offset 3
    agu(1'b1, 32'h1003, 1'b1, 2'b00, 1'b0, 2'd1, 32'h0);
    #1;
    chk("lb_mem_valid", 32'(mem_cmd_valid), 32'd1);
    chk("lb_wmask", 32'(mem_cmd_wmask), 32'h0);
    chk("lb_addr", mem_cmd_addr, 32'h1003);
    step();
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    rsp(1'b1, 32'h80FF_FF12, 1'b0);
    #1;
    chk("lb_lsu_valid", 32'(lsu_o_valid), 32'd1);
    chk("lb_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    chk("lb_wdat", lsu_o_wdat, 32'hFFFF_FF80);
    chk("lb_itag", 32'(lsu_o_itag), 32'd1);
    chk("lb_misalgn", 32'(lsu_o_misalgn), 32'd0);
    step();
    #1;
    chk("stray_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("stray_lsu_valid", 32'(lsu_o_valid), 32'd0);
    rsp(1'b0, 32'h0, 1'b0);

    // store half at offset 2
    agu(1'b1, 32'h2002, 1'b0, 2'b01, 1'b0, 2'd2, 32'hBEEF_BEEF);
    #1;
    chk("sh_wmask", 32'(mem_cmd_wmask), 32'hC);
    chk("sh_wdata", mem_cmd_wdata, 32'hBEEF_BEEF);
    chk("sh_read", 32'(mem_cmd_read), 32'd0);
    step();
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    rsp(1'b1, 32'h1234_5678, 1'b0);
    #1;
    chk("sh_wdat", lsu_o_wdat, 32'h0);
    chk("sh_err", 32'(lsu_o_err), 32'd0);
    chk("sh_itag", 32'(lsu_o_itag), 32'd2);
    step();
    rsp(1'b0, 32'h0, 1'b0);

    // fill FIFO with two loads, third must stall until a pop
    agu(1'b1, 32'h4000, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0);
    step();
    agu(1'b1, 32'h4002, 1'b1, 2'b01, 1'b1, 2'd3, 32'h0);
    step();
    agu(1'b1, 32'h4001, 1'b1, 2'b00, 1'b0, 2'd1, 32'h0);
    #1;
    chk("full_agu_ready", 32'(agu_cmd_ready), 32'd0);
    chk("full_mem_valid", 32'(mem_cmd_valid), 32'd0);
    step();
    chk("full_agu_ready2", 32'(agu_cmd_ready), 32'd0);
    rsp(1'b1, 32'hCAFE_F00D, 1'b0);
    #1;
    chk("full_pop_agu_ready", 32'(agu_cmd_ready), 32'd0);
    chk("c0_itag", 32'(lsu_o_itag), 32'd0);
    chk("c0_wdat", lsu_o_wdat, 32'hCAFE_F00D);
    step();
    rsp(1'b1, 32'h8765_4321, 1'b0);
    #1;
    chk("c1_agu_ready", 32'(agu_cmd_ready), 32'd1);
    chk("c1_itag", 32'(lsu_o_itag), 32'd3);
    chk("c1_wdat", lsu_o_wdat, 32'h0000_8765);
    step();
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    rsp(1'b1, 32'h0000_7F00, 1'b0);
    #1;
    chk("c2_itag", 32'(lsu_o_itag), 32'd1);
    chk("c2_wdat", lsu_o_wdat, 32'h0000_007F);
    step();
    rsp(1'b0, 32'h0, 1'b0);

    // misaligned word load completes locally
    lsu_o_ready = 1'b0;
    agu(1'b1, 32'h3002, 1'b1, 2'b10, 1'b0, 2'd2, 32'h0);
    #1;
    chk("mis_mem_valid", 32'(mem_cmd_valid), 32'd0);
    chk("mis_agu_ready", 32'(agu_cmd_ready), 32'd1);
    step();
    agu(1'b1, 32'h5000, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0);
    #1;
    chk("mis_lsu_valid", 32'(lsu_o_valid), 32'd1);
    chk("mis_flag", 32'(lsu_o_misalgn), 32'd1);
    chk("mis_err", 32'(lsu_o_err), 32'd0);
    chk("mis_wdat", lsu_o_wdat, 32'h0);
    chk("mis_itag", 32'(lsu_o_itag), 32'd2);
    chk("mis_block_ready", 32'(agu_cmd_ready), 32'd0);
    chk("mis_block_mem", 32'(mem_cmd_valid), 32'd0);
    step();
    chk("mis_hold_valid", 32'(lsu_o_valid), 32'd1);
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    lsu_o_ready = 1'b1;
    step();
    chk("mis_clear_valid", 32'(lsu_o_valid), 32'd0);

    // bus error held off by writeback back-pressure
    agu(1'b1, 32'h5000, 1'b1, 2'b00, 1'b0, 2'd3, 32'h0);
    step();
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    lsu_o_ready = 1'b0;
    rsp(1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err_rsp_ready_low", 32'(mem_rsp_ready), 32'd0);
      chk("err_lsu_valid", 32'(lsu_o_valid), 32'd1);
      step();
    end
    lsu_o_ready = 1'b1;
    #1;
    chk("err_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    chk("err_flag", 32'(lsu_o_err), 32'd1);
    chk("err_wdat", lsu_o_wdat, 32'h0);
    chk("err_itag", 32'(lsu_o_itag), 32'd3);
    step();
    rsp(1'b0, 32'h0, 1'b0);

    // reset with two outstanding requests
    agu(1'b1, 32'h6100, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0);
    step();
    agu(1'b1, 32'h6104, 1'b1, 2'b10, 1'b0, 2'd1, 32'h0);
    step();
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp(1'b1, 32'h5555_AAAA, 1'b0);
    #1;
    chk("rst2_lsu_valid", 32'(lsu_o_valid), 32'd0);
    chk("rst2_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    rsp(1'b0, 32'h0, 1'b0);
    agu(1'b1, 32'h6000, 1'b1, 2'b10, 1'b0, 2'd2, 32'h0);
    #1;
    chk("rst2_mem_valid", 32'(mem_cmd_valid), 32'd1);
    chk("rst2_agu_ready", 32'(agu_cmd_ready), 32'd1);
    step();
    agu(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
    rsp(1'b1, 32'h1122_3344, 1'b0);
    #1;
    chk("rst2_itag", 32'(lsu_o_itag), 32'd2);
    chk("rst2_wdat", lsu_o_wdat, 32'h1122_3344);
    step();
    rsp(1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
